// File: rtl/depth_fetch.sv
// Depth fetch stage: queues fragments, reads the stored depth word at addr+4 over Avalon-MM and
// forwards {addr,color,old_depth,new_depth,done} in order. Optional counters: `define DEPTH_FETCH_STATS_EN.
module depth_fetch #(
   parameter int PEND_LOG2 = 2,
   parameter int ADDR_W    = 26
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              frag_valid,
   input  logic [ADDR_W-1:0] frag_addr,
   input  logic [31:0]       frag_color,
   input  logic [31:0]       frag_depth,
   input  logic              frag_done,
   output logic              stall_out,
   input  logic              stall_in,
   output logic              out_valid,
   output logic [ADDR_W-1:0] out_addr,
   output logic [31:0]       out_color,
   output logic [31:0]       out_old_depth,
   output logic [31:0]       out_new_depth,
   output logic              out_done,
`ifdef DEPTH_FETCH_STATS_EN
   output logic [31:0]       stat_frags,
   output logic [31:0]       stat_mem_stall,
   output logic [31:0]       stat_ds_stall,
`endif
   output logic [ADDR_W-1:0] master_address,
   output logic              master_read,
   output logic              master_write,
   output logic [3:0]        master_byteenable,
   input  logic [31:0]       master_readdata,
   input  logic              master_readdatavalid,
   input  logic              master_waitrequest
);

   localparam int DEPTH = 2 ** PEND_LOG2;
   localparam logic [PEND_LOG2:0] CNT_FULL = (PEND_LOG2 + 1)'(DEPTH);

   logic [PEND_LOG2-1:0] head_reg, tail_reg, fill_reg;
   logic [PEND_LOG2:0]   count_reg, outst_reg;
   logic                 filled_reg [DEPTH];

   logic [ADDR_W-1:0]    q_addr  [DEPTH];
   logic [31:0]          q_color [DEPTH];
   logic [31:0]          q_depth [DEPTH];
   logic                 q_done  [DEPTH];
   logic [31:0]          q_old   [DEPTH];

   logic accept, rd_fire, ret, pop;

   assign stall_out = (count_reg == CNT_FULL) | (master_read & master_waitrequest);
   assign accept    = frag_valid & ~stall_out;
   assign rd_fire   = master_read & ~master_waitrequest;
   // Returns with nothing in flight are strays (e.g. from before a reset) and are dropped.
   assign ret       = master_readdatavalid & (outst_reg != '0);
   // filled is registered, so a return landing in the head entry pops one cycle later.
   assign pop       = filled_reg[head_reg] & ~stall_in & (count_reg != '0);

   assign master_write      = 1'b0;
   assign master_byteenable = 4'hF;

   always_ff @(posedge clock) begin
      if (accept) begin
         q_addr[tail_reg]  <= frag_addr;
         q_color[tail_reg] <= frag_color;
         q_depth[tail_reg] <= frag_depth;
         q_done[tail_reg]  <= frag_done;
      end
      if (ret) begin
         q_old[fill_reg] <= master_readdata;
      end
   end

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_filled
         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               filled_reg[gi] <= 1'b0;
            end else if (ret && fill_reg == PEND_LOG2'(gi)) begin
               filled_reg[gi] <= 1'b1;
            end else if (pop && head_reg == PEND_LOG2'(gi)) begin
               filled_reg[gi] <= 1'b0;
            end
         end
      end
   endgenerate

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head_reg  <= '0;
         tail_reg  <= '0;
         fill_reg  <= '0;
         count_reg <= '0;
         outst_reg <= '0;
      end else begin
         if (accept) tail_reg <= tail_reg + 1'b1;
         if (ret)    fill_reg <= fill_reg + 1'b1;
         if (pop)    head_reg <= head_reg + 1'b1;
         case ({accept, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
         case ({rd_fire, ret})
            2'b10:   outst_reg <= outst_reg + 1'b1;
            2'b01:   outst_reg <= outst_reg - 1'b1;
            default: outst_reg <= outst_reg;
         endcase
      end
   end

   // Accept can only happen while the bus is not stalled, so it never disturbs a held read.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         master_read    <= 1'b0;
         master_address <= '0;
      end else if (accept) begin
         master_read    <= 1'b1;
         master_address <= frag_addr + ADDR_W'(4);
      end else if (rd_fire) begin
         master_read    <= 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         out_valid     <= 1'b0;
         out_addr      <= '0;
         out_color     <= '0;
         out_old_depth <= '0;
         out_new_depth <= '0;
         out_done      <= 1'b0;
      end else begin
         out_valid <= pop;
         out_done  <= pop & q_done[head_reg];
         if (pop) begin
            out_addr      <= q_addr[head_reg];
            out_color     <= q_color[head_reg];
            out_old_depth <= q_old[head_reg];
            out_new_depth <= q_depth[head_reg];
         end
      end
   end

`ifdef DEPTH_FETCH_STATS_EN
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         stat_frags     <= '0;
         stat_mem_stall <= '0;
         stat_ds_stall  <= '0;
      end else begin
         if (out_valid && stat_frags != 32'hFFFF_FFFF)
            stat_frags <= stat_frags + 1'b1;
         if (master_read && master_waitrequest && stat_mem_stall != 32'hFFFF_FFFF)
            stat_mem_stall <= stat_mem_stall + 1'b1;
         if (filled_reg[head_reg] && stall_in && stat_ds_stall != 32'hFFFF_FFFF)
            stat_ds_stall <= stat_ds_stall + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_depth_fetch.sv
// Scoreboard bench for depth_fetch: directed fragments, Avalon memory model with programmable
// latency and waitrequest, monitor comparing every out_valid against the expected queue.
`timescale 1ns/1ps
module tb_depth_fetch;
   localparam int AW = 26;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          frag_valid = 1'b0;
   logic [AW-1:0] frag_addr = '0;
   logic [31:0]   frag_color = '0;
   logic [31:0]   frag_depth = '0;
   logic          frag_done = 1'b0;
   logic          stall_out;
   logic          stall_in = 1'b0;
   logic          out_valid;
   logic [AW-1:0] out_addr;
   logic [31:0]   out_color, out_old_depth, out_new_depth;
   logic          out_done;
`ifdef DEPTH_FETCH_STATS_EN
   logic [31:0]   stat_frags, stat_mem_stall, stat_ds_stall;
`endif
   logic [AW-1:0] master_address;
   logic          master_read, master_write;
   logic [3:0]    master_byteenable;
   logic [31:0]   master_readdata = '0;
   logic          master_readdatavalid = 1'b0;
   logic          master_waitrequest = 1'b0;

   depth_fetch #(.PEND_LOG2(2), .ADDR_W(AW)) dut (
      .clock(clock), .reset(reset),
      .frag_valid(frag_valid), .frag_addr(frag_addr), .frag_color(frag_color),
      .frag_depth(frag_depth), .frag_done(frag_done), .stall_out(stall_out),
      .stall_in(stall_in), .out_valid(out_valid), .out_addr(out_addr),
      .out_color(out_color), .out_old_depth(out_old_depth), .out_new_depth(out_new_depth),
      .out_done(out_done),
`ifdef DEPTH_FETCH_STATS_EN
      .stat_frags(stat_frags), .stat_mem_stall(stat_mem_stall), .stat_ds_stall(stat_ds_stall),
`endif
      .master_address(master_address), .master_read(master_read), .master_write(master_write),
      .master_byteenable(master_byteenable), .master_readdata(master_readdata),
      .master_readdatavalid(master_readdatavalid), .master_waitrequest(master_waitrequest)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [31:0]   color;
      logic [31:0]   old_d;
      logic [31:0]   new_d;
      logic          done;
   } out_t;
   typedef struct {
      logic [31:0] data;
      int          due;
   } ret_t;

   out_t          exp_q[$];
   logic [AW-1:0] rdaddr_q[$];
   ret_t          mem_q[$];
   int            rd_cyc_q[$];
   int            out_cyc_q[$];
   logic [31:0]   mem_tab [logic [AW-1:0]];

   int tests = 0, fails = 0;
   int cyc = 0, lat = 2, wr_budget = 0;
   int out_cnt = 0, stall_cyc = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end else begin
         $display("[TB] ok %s = 0x%0h", name, act);
      end
   endtask

   task automatic flag(input string name);
      tests++;
      fails++;
      $display("FAIL %s: event occurred, required none", name);
   endtask

   function automatic logic [31:0] mem_rd(input logic [AW-1:0] a);
      if (mem_tab.exists(a)) return mem_tab[a];
      return {6'd0, a} ^ 32'h5A5A_0000;
   endfunction

   // Avalon slave model: fixed latency, in-order returns, optional waitrequest burst.
   initial begin
      forever begin
         @(posedge clock);
         #1;
         if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            master_readdatavalid = 1'b1;
            master_readdata      = mem_q[0].data;
            mem_q.delete(0);
         end else begin
            master_readdatavalid = 1'b0;
            master_readdata      = '0;
         end
         if (master_read && wr_budget > 0) begin
            master_waitrequest = 1'b1;
            wr_budget--;
         end else begin
            master_waitrequest = 1'b0;
         end
      end
   end

   // Monitor: read issue checks and output scoreboard.
   initial begin
      out_t e;
      forever begin
         @(negedge clock);
         if (reset) begin
            if (stall_out) stall_cyc++;
            if (master_read && master_waitrequest && rdaddr_q.size() > 0)
               check("read_addr_hold", 64'(master_address), 64'(rdaddr_q[0]));
            if (master_read && !master_waitrequest) begin
               mem_q.push_back('{data: mem_rd(master_address), due: cyc + lat});
               rd_cyc_q.push_back(cyc);
               if (rdaddr_q.size() == 0) flag("read_unexpected");
               else check("read_addr", 64'(master_address), 64'(rdaddr_q.pop_front()));
            end
            if (out_valid) begin
               out_cnt++;
               out_cyc_q.push_back(cyc);
               if (exp_q.size() == 0) begin
                  flag("out_unexpected");
               end else begin
                  e = exp_q.pop_front();
                  tests++;
                  if (out_addr !== e.addr || out_color !== e.color || out_old_depth !== e.old_d ||
                      out_new_depth !== e.new_d || out_done !== e.done) begin
                     fails++;
                     $display("FAIL out_pkt: got a=%0h c=%0h old=%0h new=%0h d=%0b expected a=%0h c=%0h old=%0h new=%0h d=%0b",
                              out_addr, out_color, out_old_depth, out_new_depth, out_done,
                              e.addr, e.color, e.old_d, e.new_d, e.done);
                  end else begin
                     $display("[TB] out a=%0h old=%0h new=%0h done=%0b", out_addr, out_old_depth, out_new_depth, out_done);
                  end
               end
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
   task automatic send(input logic [AW-1:0] a, input logic [31:0] c, input logic [31:0] d,
                       input logic dn, output int waited);
      logic [AW-1:0] a4;
      a4 = a + AW'(4);
      frag_valid = 1'b1; frag_addr = a; frag_color = c; frag_depth = d; frag_done = dn;
      waited = 0;
      forever begin
         @(negedge clock);
         if (!stall_out) break;
         waited++;
         if (waited > 200) begin
            flag("accept_timeout");
            break;
         end
      end
      exp_q.push_back('{addr: a, color: c, old_d: mem_rd(a4), new_d: d, done: dn});
      rdaddr_q.push_back(a4);
      @(posedge clock);
      #1;
      frag_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic drain();
      int k = 0;
      while (exp_q.size() > 0 && k < 500) begin
         @(posedge clock);
         k++;
      end
      #1;
      if (exp_q.size() > 0) flag("drain_timeout");
      idle(2);
   endtask

   initial begin
      int w, sum, oc;
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, w2, sum, oc;
      // Reset state
      repeat (3) @(negedge clock);
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_master_read", 64'(master_read), 64'(0));
      check("rst_stall_out", 64'(stall_out), 64'(0));
      check("rst_out_fields", 64'({out_addr, out_done}) | 64'(out_old_depth), 64'(0));
      check("tied_write", 64'(master_write), 64'(0));
      check("tied_be", 64'(master_byteenable), 64'hF);
      @(posedge clock); #1;
      reset = 1'b1;
      idle(2);

      // 1: single fragment
      mem_tab[AW'(32'h104)] = 32'd9;
      lat = 2;
      send(AW'(32'h100), 32'hAABBCC, 32'd5, 1'b0, w);
      drain();

      // 2: four back-to-back, fifth held off by full queue
      lat = 6;
      rd_cyc_q.delete();
      sum = 0;
      for (int i = 0; i < 4; i++) begin
         send(AW'(32'h1000 + 16 * i), 32'h1100 + i, 32'h20 + i, 1'b0, w);
         sum += w;
      end
      check("b2b_no_stall", 64'(sum), 64'(0));
      send(AW'(32'h2000), 32'h1199, 32'h99, 1'b0, w);
      check("full_stall_seen", 64'(w > 0), 64'(1));
      drain();
      for (int i = 1; i < 4; i++)
         check("b2b_read_gap", 64'(rd_cyc_q[i] - rd_cyc_q[i-1]), 64'(1));

      // 3: waitrequest held 3 cycles on first read
      lat = 3;
      wr_budget = 3;
      stall_cyc = 0;
      send(AW'(32'h3000), 32'h33, 32'h3, 1'b0, w);
      send(AW'(32'h3010), 32'h34, 32'h4, 1'b0, w2);
      check("wr_frag_wait", 64'(w2), 64'(3));
      drain();
      check("wr_stall_cycles", 64'(stall_cyc), 64'(3));

      // 4: downstream stall while all four returns land
      lat = 2;
      stall_in = 1'b1;
      oc = out_cnt;
      for (int i = 0; i < 4; i++)
         send(AW'(32'h4000 + 8 * i), 32'h4400 + i, 32'h40 + i, 1'b0, w);
      idle(10);
      check("stall_in_hold", 64'(out_cnt - oc), 64'(0));
      out_cyc_q.delete();
      stall_in = 1'b0;
      drain();
      check("release_count", 64'(out_cyc_q.size()), 64'(4));
      for (int i = 1; i < out_cyc_q.size(); i++)
         check("release_consecutive", 64'(out_cyc_q[i] - out_cyc_q[i-1]), 64'(1));

      // 5: done on last of three, including address wrap at the top of the space
      send(AW'(32'h5000), 32'h55, 32'h50, 1'b0, w);
      send(AW'(32'h5004), 32'h56, 32'h51, 1'b0, w);
      send(AW'(32'h3FF_FFFC), 32'h57, 32'h52, 1'b1, w);
      drain();
`ifdef DEPTH_FETCH_STATS_EN
      check("stat_frags", 64'(stat_frags), 64'(out_cnt));
      check("stat_mem_stall", 64'(stat_mem_stall), 64'(3));
`endif

      // 6: reset with two reads outstanding, stray returns afterwards
      lat = 20;
      send(AW'(32'h6000), 32'h66, 32'h60, 1'b0, w);
      send(AW'(32'h6010), 32'h67, 32'h61, 1'b0, w);
      idle(3);
      #2 reset = 1'b0;
      #1;
      check("async_rst_read", 64'(master_read), 64'(0));
      check("async_rst_stall", 64'(stall_out), 64'(0));
      exp_q.delete();
      rdaddr_q.delete();
      idle(3);
      reset = 1'b1;
      oc = out_cnt;
      idle(30);
      check("stray_ignored", 64'(out_cnt - oc), 64'(0));
      check("stray_mem_drained", 64'(mem_q.size()), 64'(0));
`ifdef DEPTH_FETCH_STATS_EN
      check("stat_frags_rst", 64'(stat_frags), 64'(0));
      check("stat_mem_rst", 64'(stat_mem_stall), 64'(0));
      check("stat_ds_rst", 64'(stat_ds_stall), 64'(0));
`endif
      // Queue works normally after the strays
      lat = 2;
      mem_tab[AW'(32'h7004)] = 32'hCAFE;
      send(AW'(32'h7000), 32'h77, 32'h70, 1'b1, w);
      drain();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
